edge_pair_gen: RTL and testbench

Clocked stimulus generator producing a start edge followed by a stop edge exactly a programmed number of clock cycles later. It is the driving end of a start-to-stop delay measurement: its `start_out`/`stop_out` pair feeds a delay meter's first and second inputs, so the meter's reading can be checked against a known cycle count. It sits in sample benches and self-test harnesses, driven by a sequencer over a single-cycle req/ack handshake.

---
 rtl/edge_pair_gen.sv | 144 ++++++++++++++
 tb/tb_edge_pair_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/edge_pair_gen.sv
// edge_pair_gen: emits a start edge, then a stop edge a programmed number of cycles later.
// Defining EDGE_PAIR_GEN_BURST_EN adds the nrpt port and back-to-back repeated pairs.
module edge_pair_gen #(
  parameter int unsigned DW        = 16,
  parameter logic        START_DIR = 1'b1,
  parameter logic        STOP_DIR  = 1'b1,
  parameter int unsigned NRPT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  // req/ack: req is only looked at in IDLE; the cycle it is seen high, ack pulses
  // for exactly one cycle and delay/hold (and nrpt) are captured. No queueing.
  input  logic              req,
  input  logic [DW-1:0]     delay,
  input  logic [DW-1:0]     hold,
`ifdef EDGE_PAIR_GEN_BURST_EN
  input  logic [NRPT_W-1:0] nrpt,
`endif
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic              start_out,
  output logic              stop_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_STOP  = 2'd2;
  localparam logic [1:0] S_REARM = 2'd3;

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [DW-1:0]     hld_q, hld_d;
  logic [NRPT_W-1:0] rpt_q, rpt_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic [NRPT_W-1:0] rpt_load;

`ifdef EDGE_PAIR_GEN_BURST_EN
  assign rpt_load = nrpt;
`else
  assign rpt_load = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    hld_d   = hld_q;
    rpt_d   = rpt_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    start_d = start_q;
    stop_d  = stop_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          dly_d   = (delay == '0) ? ONE : delay;
          hld_d   = (hold == '0) ? ONE : hold;
          rpt_d   = rpt_load;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          start_d = START_DIR;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      // Counter compares against value-1 so a delay of 2^DW-1 never needs 2^DW.
      S_START: begin
        if (cnt_q == dly_q - ONE) begin
          stop_d  = STOP_DIR;
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == hld_q - ONE) begin
          start_d = ~START_DIR;
          stop_d  = ~STOP_DIR;
          cnt_d   = '0;
          if (rpt_q != '0) begin
            rpt_d   = rpt_q - 1'b1;
            state_d = S_REARM;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      // One cycle at idle level between burst pairs, then restart.
      S_REARM: begin
        start_d = START_DIR;
        cnt_d   = '0;
        state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dly_q   <= ONE;
      hld_q   <= ONE;
      rpt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= ~START_DIR;
      stop_q  <= ~STOP_DIR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      hld_q   <= hld_d;
      rpt_q   <= rpt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign start_out = start_q;
  assign stop_out  = stop_q;

endmodule

// File: tb/tb_edge_pair_gen.sv
// Directed bench for edge_pair_gen: default instance plus an inverted-start instance.
module tb_edge_pair_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req1;
  logic [15:0] delay, hold, delay1, hold1;
  logic        ack, busy, done, start_out, stop_out;
  logic        ack1, busy1, done1, start1, stop1;
`ifdef EDGE_PAIR_GEN_BURST_EN
  logic [7:0]  nrpt, nrpt1;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  edge_pair_gen dut (
    .clk(clk), .rst(rst), .req(req), .delay(delay), .hold(hold),
`ifdef EDGE_PAIR_GEN_BURST_EN
    .nrpt(nrpt),
`endif
    .ack(ack), .busy(busy), .done(done), .start_out(start_out), .stop_out(stop_out)
  );

  edge_pair_gen #(.START_DIR(1'b0), .STOP_DIR(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .req(req1), .delay(delay1), .hold(hold1),
`ifdef EDGE_PAIR_GEN_BURST_EN
    .nrpt(nrpt1),
`endif
    .ack(ack1), .busy(busy1), .done(done1), .start_out(start1), .stop_out(stop1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard: measured start-to-stop spacing of the default instance
  logic prev_start = 1'b0, prev_stop = 1'b0, counting = 1'b0;
  int   span = 0;
  always @(negedge clk) begin
    if (rst) begin
      counting = 1'b0;
    end else begin
      if (counting) span++;
      if (start_out && !prev_start) begin
        counting = 1'b1;
        span = 0;
      end
      if (stop_out && !prev_stop && counting) begin
        chk("span_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("span", span, exp_q.pop_front());
        counting = 1'b0;
      end
    end
    prev_start = start_out;
    prev_stop  = stop_out;
  end

  // Called at the negedge right after the accept edge; checks every cycle to release.
  task automatic pair_body(input int d, input int h, input int poke);
    chk("acc_ack", ack, 1);
    chk("acc_busy", busy, 1);
    chk("acc_start", start_out, 1);
    chk("acc_stop", stop_out, 0);
    chk("acc_done", done, 0);
    for (int j = 1; j <= d + h; j++) begin
      @(negedge clk);
      chk("p_start", start_out, 32'(j < d + h));
      chk("p_stop", stop_out, 32'(j >= d && j < d + h));
      chk("p_done", done, 32'(j == d + h));
      chk("p_busy", busy, 32'(j < d + h));
      chk("p_ack", ack, 0);
      if (j == poke) begin
        req = 1'b1; delay = 16'd2; hold = 16'd9;
      end else if (j == poke + 1) begin
        req = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; delay = '0; hold = '0;
    req1 = 1'b0; delay1 = '0; hold1 = '0;
`ifdef EDGE_PAIR_GEN_BURST_EN
    nrpt = '0; nrpt1 = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", start_out, 0);
    chk("rst_stop", stop_out, 0);
    chk("rst_inv_start", start1, 1);
    chk("rst_inv_stop", stop1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rel_busy", busy, 0);
    chk("rel_start", start_out, 0);
    chk("rel_ack", ack, 0);

    // nominal 7/3, with a req poke and changed inputs mid-START
    req = 1'b1; delay = 16'd7; hold = 16'd3; exp_q.push_back(7);
    @(negedge clk); req = 1'b0;
    pair_body(7, 3, 4);

    // zero delay/hold clamp to 1
    @(negedge clk); req = 1'b1; delay = 16'd0; hold = 16'd0; exp_q.push_back(1);
    @(negedge clk); req = 1'b0;
    pair_body(1, 1, -1);

    // req held high: re-accepted one idle cycle after done
    @(negedge clk); req = 1'b1; delay = 16'd3; hold = 16'd2; exp_q.push_back(3);
    @(negedge clk);
    pair_body(3, 2, -1);
    exp_q.push_back(3);
    @(negedge clk); req = 1'b0;
    pair_body(3, 2, -1);

    // inverted start direction instance
    @(negedge clk); req1 = 1'b1; delay1 = 16'd4; hold1 = 16'd2;
    @(negedge clk); req1 = 1'b0;
    chk("inv_ack", ack1, 1);
    chk("inv_start_acc", start1, 0);
    chk("inv_stop_acc", stop1, 0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk("inv_start", start1, 32'(j >= 6));
      chk("inv_stop", stop1, 32'(j >= 4 && j < 6));
      chk("inv_done", done1, 32'(j == 6));
    end

    // asynchronous reset in the middle of START
    @(negedge clk); req = 1'b1; delay = 16'd10; hold = 16'd3;
    @(negedge clk); req = 1'b0;
    chk("mid_start_pre", start_out, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_start", start_out, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_stop", stop_out, 0);
    end

`ifdef EDGE_PAIR_GEN_BURST_EN
    // burst: three pairs of 3/2, six cycles apart
    @(negedge clk); req = 1'b1; delay = 16'd3; hold = 16'd2; nrpt = 8'd2;
    repeat (3) exp_q.push_back(3);
    @(negedge clk); req = 1'b0; nrpt = 8'd0;
    chk("b_ack", ack, 1);
    for (int j = 0; j < 18; j++) begin
      if (j != 0) @(negedge clk);
      chk("b_start", start_out, 32'((j % 6) < 5));
      chk("b_stop", stop_out, 32'((j % 6) >= 3 && (j % 6) < 5));
      chk("b_busy", busy, 32'(j != 17));
      chk("b_done", done, 32'(j == 17));
    end
`endif

    // maximum delay must not wrap
    @(negedge clk); req = 1'b1; delay = 16'hFFFF; hold = 16'd1; exp_q.push_back(65535);
    @(negedge clk); req = 1'b0;
    chk("max_start", start_out, 1);
    repeat (65534) @(negedge clk);
    chk("max_stop_early", stop_out, 0);
    chk("max_start_held", start_out, 1);
    @(negedge clk);
    chk("max_stop", stop_out, 1);
    @(negedge clk);
    chk("max_done", done, 1);
    chk("max_rel_start", start_out, 0);
    chk("max_rel_stop", stop_out, 0);

    repeat (2) @(negedge clk);
    chk("span_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
